// File: rtl/dbnc_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
// The counter-sizing helper keeps power-of-two DB_CYCLES values from under-sizing the counter.
package dbnc_pkg;

  localparam int DB_CYCLES_HW  = 1000000;
  localparam int DB_CYCLES_SIM = 4;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounce channel: synchroniser chain, persistence counter, stable level and edge strobes.
// Only the first synchroniser flop ever sees the asynchronous input.
module debounce_bit
  import dbnc_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_HW,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_raw,
  output logic q_clean,
  output logic q_rise,
  output logic q_fall
);

  localparam int             CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   sync_out;

  assign sync_out = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      q_clean <= 1'b0;
      q_rise  <= 1'b0;
      q_fall  <= 1'b0;
    end else begin
      // synchroniser stage -> persistence stage
      sync   <= {sync[SYNC_STAGES-2:0], d_raw};
      q_rise <= 1'b0;
      q_fall <= 1'b0;
      if (sync_out == q_clean) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        // DB_CYCLES-th consecutive mismatch: accept the new level
        q_clean <= sync_out;
        cnt     <= '0;
        q_rise  <= sync_out;
        q_fall  <= ~sync_out;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_debouncer.sv
// Debounces a vector of slide switches, one independent channel per bit,
// and flags any accepted change on sw_changed.
module sw_debouncer
  import dbnc_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int DB_CYCLES   = DB_CYCLES_HW,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_bit #(
      .DB_CYCLES  (DB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_raw  (sw_raw[i]),
      .q_clean(sw_clean[i]),
      .q_rise (sw_rise[i]),
      .q_fall (sw_fall[i])
    );
  end

  // Built only from registered strobes, so still no path from sw_raw.
  assign sw_changed = |{sw_rise, sw_fall};

endmodule

// File: doc/sw_debouncer.md
Name: sw_debouncer

Overview:
- Upstream conditioning stage between the board slide switches and the combinational gate block that drives the LEDs.
- Synchronises each raw asynchronous switch bit into the clk domain and debounces it.
- Presents a glitch-free switch vector to the gate block.
- Also produces one-cycle rise/fall strobes for later sequential consumers (counters, FSM demos).

Parameters:
WIDTH, 2, number of switch bits handled (one independent channel per bit)
DB_CYCLES, 1000000, consecutive clk cycles a new level must persist before acceptance (10 ms at 100 MHz); legal range >= 1
SYNC_STAGES, 2, synchroniser flop depth; legal range >= 2

Ports:
clk  input  1  system clock (100 MHz on board)
rst_n  input  1  synchronous active-low reset, sampled on rising clk
sw_raw  input  WIDTH  raw asynchronous slide-switch levels
sw_clean  output  WIDTH  debounced stable levels, fed directly to the gate block input vector
sw_rise  output  WIDTH  one-cycle pulse per bit when sw_clean bit goes 0->1
sw_fall  output  WIDTH  one-cycle pulse per bit when sw_clean bit goes 1->0
sw_changed  output  1  OR of all sw_rise and sw_fall bits, same cycle

Behaviour:
- Reset: one clock, synchronous, active-low. While rst_n=0 at a rising edge, all of the following are cleared to 0:
  - synchroniser flops, counters, sw_clean, sw_rise, sw_fall, sw_changed.
  - No strobe fires on the first cycle after reset, even if sw_raw is 1. A 1 input is accepted through normal debounce and produces a sw_rise at that point.
- All outputs are registered. No combinational path from sw_raw to any output.
- Per bit, the channels are fully independent:
  - sync chain: SYNC_STAGES flops; sync_out is the last stage.
  - cnt: width $clog2(DB_CYCLES+1), unsigned.
  - Each edge, if sync_out == sw_clean: cnt <= 0.
  - Each edge, if sync_out != sw_clean and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - Each edge, if sync_out != sw_clean and cnt == DB_CYCLES-1: sw_clean <= sync_out, cnt <= 0, and the matching rise/fall strobe is 1 for exactly that following cycle.
- Any bounce back to the old level before acceptance resets cnt. Acceptance requires DB_CYCLES consecutive mismatching samples.
- Latency for a clean step: let E1 be the first rising edge that samples the new sw_raw level. sw_clean updates at edge E(SYNC_STAGES + DB_CYCLES). With defaults this is E(DB_CYCLES+2).
- Strobes:
  - sw_rise/sw_fall are high only in the cycle immediately after sw_clean changes, otherwise 0.
  - A bit can never show rise and fall together.
- Simultaneous events: bits that qualify on the same edge update together. Their strobes are asserted in the same cycle; sw_changed is a single 1.
- cnt saturation: cnt never exceeds DB_CYCLES-1, so no wrap-around.
- DB_CYCLES=1 is legal: acceptance occurs on the first mismatching sample, cnt stays 0.
- Reset mid-debounce: cnt and sw_clean are cleared. A pending transition toward 1 is discarded and must re-qualify from zero after release.
- Metastability: only the first sync flop samples sw_raw. Downstream logic uses only sync_out.

Decomposition:
- Package dbnc_pkg holds:
  - DB_CYCLES_HW = 1000000 and DB_CYCLES_SIM = 4.
  - A function cnt_width(n) returning $clog2(n+1), so the counter is not under-sized when DB_CYCLES is a power of two.
- Sub-module debounce_bit: one channel (sync chain, counter, stable flop, rise/fall). Ports: clk, rst_n, d_raw, q_clean, q_rise, q_fall.
- sw_debouncer instantiates WIDTH copies in a generate loop and ORs the strobes into sw_changed.
- The top-level wrapper connects sw to sw_raw and sw_clean to the gate block's input.

Test Plan:
Bench settings: DB_CYCLES=4, SYNC_STAGES=2, WIDTH=2.
1. rst_n=0 for 3 cycles with sw_raw=2'b11 -> all outputs 0 during reset. After release, sw_clean=2'b11 at edge 6 counted from the first post-reset edge; sw_rise=2'b11 and sw_changed=1 for exactly 1 cycle.
2. From steady 2'b00, step sw_raw[0] to 1 at E1 -> sw_clean=2'b01 at E6, sw_rise=2'b01 for one cycle, sw_fall=0, sw_clean[1] untouched.
3. Bounce: sw_raw[1] = 1,0,1,0 on alternate cycles, then held 1 -> no sw_clean/strobe change during bouncing. sw_clean[1]=1 exactly 6 edges after the final 0->1 step.
4. Glitch: a 3-cycle 1 pulse on sw_raw[0] from steady 0 -> sw_clean stays 2'b00 and no strobes. A 4-cycle pulse is accepted, then released after another 4-cycle low.
5. Simultaneous: from 2'b01, both bits toggle on the same edge to 2'b10 -> sw_clean goes 2'b01->2'b10 on one edge, sw_rise=2'b10 and sw_fall=2'b01 in the same cycle, sw_changed=1 for one cycle.
6. Reset mid-debounce: sw_raw[0] steps 0->1, then rst_n=0 for 1 cycle at 3 mismatching samples -> sw_clean stays 0. After release, acceptance takes the full 6 edges again; sw_rise[0] fires once.
